// File: rtl/forward_source_tracker_if.sv
// Bundle between the EX/M/W forwarding tracker and its surroundings:
// pipeline control, the EX result, the load response, and the bypass /
// write-back outputs. The tracker takes the slave view.
interface forward_source_tracker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 5
);
  logic                  hold;
  logic                  flush;
  logic                  exValid;
  logic [REG_BITS-1:0]   exReg;
  logic                  exReady;
  logic [DATA_WIDTH-1:0] exValue;
  logic                  memRespValid;
  logic [DATA_WIDTH-1:0] memRespData;
  logic                  stallMem;
  logic                  src1Valid;
  logic [REG_BITS-1:0]   src1Reg;
  logic [DATA_WIDTH-1:0] src1Value;
  logic                  src2Valid;
  logic [REG_BITS-1:0]   src2Reg;
  logic [DATA_WIDTH-1:0] src2Value;
  logic                  wbEn;
  logic [REG_BITS-1:0]   wbReg;
  logic [DATA_WIDTH-1:0] wbValue;
  logic                  respTimeout;

  modport master (
    output hold, flush, exValid, exReg, exReady, exValue, memRespValid, memRespData,
    input  stallMem, src1Valid, src1Reg, src1Value, src2Valid, src2Reg, src2Value,
           wbEn, wbReg, wbValue, respTimeout
  );

  modport slave (
    input  hold, flush, exValid, exReg, exReady, exValue, memRespValid, memRespData,
    output stallMem, src1Valid, src1Reg, src1Value, src2Valid, src2Reg, src2Value,
           wbEn, wbReg, wbValue, respTimeout
  );
endinterface

// File: rtl/forward_source_tracker.sv
// Tracks results in flight in the M and W stages and presents them as
// bypass sources (M -> src1, W -> src2). Loads park in M until their data
// returns; responses owed to flushed loads are counted and thrown away.
module forward_source_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic resetn,
  forward_source_tracker_if.slave bus
);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TMAX = WW'(TIMEOUT);

  logic                  mActive, mReady;
  logic [REG_BITS-1:0]   mReg;
  logic [DATA_WIDTH-1:0] mValue;
  logic                  wActive;
  logic [REG_BITS-1:0]   wReg;
  logic [DATA_WIDTH-1:0] wValue;
  logic [2:0]            dropCnt;
  logic [WW-1:0]         waitCnt;
  logic                  respTimeout;

  logic mPending, advM, respHit, dropInc, dropDec;

  assign mPending = mActive && !mReady;
  assign advM     = !bus.hold && !mPending;
  // A beat only completes the load in M if nothing older is owed a drop and
  // M is not being flushed this same cycle (then the beat is the flushed load's).
  assign respHit  = bus.memRespValid && (dropCnt == 3'd0) && mPending && !bus.flush;
  assign dropDec  = bus.memRespValid && (dropCnt != 3'd0);
  assign dropInc  = bus.flush && mPending && !(bus.memRespValid && (dropCnt == 3'd0));

  // M/W stage movement: flush > hold > advance > bubble into W.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mActive <= 1'b0;
      mReady  <= 1'b0;
      mReg    <= '0;
      mValue  <= '0;
      wActive <= 1'b0;
      wReg    <= '0;
      wValue  <= '0;
    end else if (bus.flush) begin
      mActive <= 1'b0;
      mReady  <= 1'b0;
      mReg    <= '0;
      mValue  <= '0;
      if (!bus.hold) begin
        wActive <= 1'b0;
        wReg    <= '0;
        wValue  <= '0;
      end
    end else if (bus.hold) begin
      if (respHit) begin
        mValue <= bus.memRespData;
        mReady <= 1'b1;
      end
    end else if (advM) begin
      wActive <= mActive;
      wReg    <= mReg;
      wValue  <= mValue;
      if (bus.exValid) begin
        mActive <= 1'b1;
        mReady  <= bus.exReady;
        mReg    <= bus.exReg;
        mValue  <= bus.exReady ? bus.exValue : '0;
      end else begin
        mActive <= 1'b0;
        mReady  <= 1'b0;
        mReg    <= '0;
        mValue  <= '0;
      end
    end else begin
      wActive <= 1'b0;
      wReg    <= '0;
      wValue  <= '0;
      if (respHit) begin
        mValue <= bus.memRespData;
        mReady <= 1'b1;
      end
    end
  end

  // Count of outstanding responses that belong to flushed loads, saturating at 7.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dropCnt <= 3'd0;
    end else if (dropInc && !dropDec) begin
      if (dropCnt != 3'd7) dropCnt <= dropCnt + 3'd1;
    end else if (dropDec && !dropInc) begin
      dropCnt <= dropCnt - 3'd1;
    end
  end

  // Load wait timer and sticky timeout flag; TIMEOUT=0 pins the timer at 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      waitCnt     <= '0;
      respTimeout <= 1'b0;
    end else if (!mPending) begin
      waitCnt <= '0;
    end else if (waitCnt != TMAX) begin
      waitCnt <= waitCnt + 1'b1;
      if ((TIMEOUT != 0) && ((waitCnt + 1'b1) == TMAX)) respTimeout <= 1'b1;
    end
  end

  assign bus.stallMem    = mPending;
  assign bus.src1Valid   = mActive && mReady;
  assign bus.src1Reg     = mActive ? mReg : '0;
  assign bus.src1Value   = mValue;
  assign bus.src2Valid   = wActive;
  assign bus.src2Reg     = wActive ? wReg : '0;
  assign bus.src2Value   = wValue;
  assign bus.wbEn        = wActive && !bus.hold && (wReg != '0);
  assign bus.wbReg       = wReg;
  assign bus.wbValue     = wValue;
  assign bus.respTimeout = respTimeout;
endmodule

// File: tb/tb_forward_source_tracker.sv
// Directed bench for forward_source_tracker: ALU forwarding, loads, flush
// drop accounting, hold, register 0 and the load timeout.
module tb_forward_source_tracker;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;
  int pulses;

  always #5 clk = ~clk;

  forward_source_tracker_if #(.DATA_WIDTH(32), .REG_BITS(5)) bus ();

  forward_source_tracker #(.DATA_WIDTH(32), .REG_BITS(5), .TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave)
  );

  task automatic idle();
    bus.hold = 0; bus.flush = 0; bus.exValid = 0; bus.exReg = 0; bus.exReady = 0;
    bus.exValue = 0; bus.memRespValid = 0; bus.memRespData = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] r, input logic rdy, input logic [31:0] v);
    bus.exValid = 1; bus.exReg = r; bus.exReady = rdy; bus.exValue = v;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    resetn = 0;
    issue(5'd3, 1'b1, 32'h55);
    bus.memRespValid = 1;
    @(negedge clk);
    tests_run++; if ({bus.stallMem, bus.src1Valid, bus.src2Valid, bus.wbEn, bus.respTimeout} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags got %b exp 00000", {bus.stallMem, bus.src1Valid, bus.src2Valid, bus.wbEn, bus.respTimeout}); end
    @(posedge clk); #1;
    resetn = 1;
    idle();
    @(negedge clk);
    tests_run++; if ({bus.src1Reg, bus.src2Reg, bus.wbReg, bus.stallMem, bus.src1Valid} !== 17'b0) begin tests_failed++; $display("FAIL reset_release got %h exp 0", {bus.src1Reg, bus.src2Reg, bus.wbReg, bus.stallMem, bus.src1Valid}); end
    tests_run++; if (bus.wbValue !== 32'h0) begin tests_failed++; $display("FAIL reset_wbValue got %h exp 0", bus.wbValue); end
  endtask

  task automatic test_alu();
    do_reset();
    issue(5'd3, 1'b1, 32'h11);
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.src1Reg !== 5'd3 || bus.src1Valid !== 1'b1) begin tests_failed++; $display("FAIL alu_t1_src1 got reg %0d valid %b exp reg 3 valid 1", bus.src1Reg, bus.src1Valid); end
    tests_run++; if (bus.src1Value !== 32'h11) begin tests_failed++; $display("FAIL alu_t1_value got %h exp 11", bus.src1Value); end
    tests_run++; if (bus.wbEn !== 1'b0) begin tests_failed++; $display("FAIL alu_t1_wbEn got %b exp 0", bus.wbEn); end
    next_cycle(); @(negedge clk);
    tests_run++; if (bus.src2Reg !== 5'd3 || bus.src2Valid !== 1'b1) begin tests_failed++; $display("FAIL alu_t2_src2 got reg %0d valid %b exp reg 3 valid 1", bus.src2Reg, bus.src2Valid); end
    tests_run++; if (bus.wbEn !== 1'b1 || bus.wbReg !== 5'd3 || bus.wbValue !== 32'h11) begin tests_failed++; $display("FAIL alu_t2_wb got en %b reg %0d val %h exp 1 3 11", bus.wbEn, bus.wbReg, bus.wbValue); end
    tests_run++; if (bus.src1Valid !== 1'b0 || bus.src1Reg !== 5'd0) begin tests_failed++; $display("FAIL alu_t2_src1_empty got valid %b reg %0d exp 0 0", bus.src1Valid, bus.src1Reg); end
    next_cycle(); @(negedge clk);
    tests_run++; if (bus.wbEn !== 1'b0 || bus.src2Valid !== 1'b0) begin tests_failed++; $display("FAIL alu_t3_drained got wbEn %b src2Valid %b exp 0 0", bus.wbEn, bus.src2Valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(5'd3, 1'b1, 32'h11);
    next_cycle(); issue(5'd4, 1'b1, 32'h22);
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.src1Reg !== 5'd4 || bus.src1Value !== 32'h22) begin tests_failed++; $display("FAIL b2b_src1 got reg %0d val %h exp 4 22", bus.src1Reg, bus.src1Value); end
    tests_run++; if (bus.src2Reg !== 5'd3 || bus.src2Value !== 32'h11) begin tests_failed++; $display("FAIL b2b_src2 got reg %0d val %h exp 3 11", bus.src2Reg, bus.src2Value); end
    next_cycle(); @(negedge clk);
    tests_run++; if (bus.wbEn !== 1'b1 || bus.wbReg !== 5'd4 || bus.wbValue !== 32'h22) begin tests_failed++; $display("FAIL b2b_wb2 got en %b reg %0d val %h exp 1 4 22", bus.wbEn, bus.wbReg, bus.wbValue); end
  endtask

  task automatic test_load();
    do_reset();
    issue(5'd5, 1'b0, 32'hFFFF);
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.stallMem !== 1'b1 || bus.src1Valid !== 1'b0) begin tests_failed++; $display("FAIL load_t1 got stall %b valid %b exp 1 0", bus.stallMem, bus.src1Valid); end
    tests_run++; if (bus.src1Reg !== 5'd5 || bus.src1Value !== 32'h0) begin tests_failed++; $display("FAIL load_t1_entry got reg %0d val %h exp 5 0", bus.src1Reg, bus.src1Value); end
    next_cycle(); @(negedge clk);
    tests_run++; if (bus.stallMem !== 1'b1 || bus.src2Valid !== 1'b0) begin tests_failed++; $display("FAIL load_t2 got stall %b src2Valid %b exp 1 0", bus.stallMem, bus.src2Valid); end
    next_cycle(); bus.memRespValid = 1; bus.memRespData = 32'hCAFE;
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.src1Valid !== 1'b1 || bus.stallMem !== 1'b0 || bus.src1Value !== 32'hCAFE) begin tests_failed++; $display("FAIL load_t4 got valid %b stall %b val %h exp 1 0 cafe", bus.src1Valid, bus.stallMem, bus.src1Value); end
    next_cycle(); @(negedge clk);
    tests_run++; if (bus.wbEn !== 1'b1 || bus.wbReg !== 5'd5 || bus.wbValue !== 32'hCAFE) begin tests_failed++; $display("FAIL load_t5_wb got en %b reg %0d val %h exp 1 5 cafe", bus.wbEn, bus.wbReg, bus.wbValue); end
  endtask

  task automatic test_flush_drop();
    do_reset();
    issue(5'd7, 1'b0, 32'h0);
    next_cycle(); idle(); bus.flush = 1;
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.stallMem !== 1'b0 || bus.src1Reg !== 5'd0) begin tests_failed++; $display("FAIL flush_empty got stall %b reg %0d exp 0 0", bus.stallMem, bus.src1Reg); end
    tests_run++; if (bus.src2Valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_w got src2Valid %b exp 0", bus.src2Valid); end
    issue(5'd8, 1'b0, 32'h0);
    next_cycle(); idle(); bus.memRespValid = 1; bus.memRespData = 32'hBAD;
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.stallMem !== 1'b1 || bus.src1Valid !== 1'b0) begin tests_failed++; $display("FAIL flush_discard got stall %b valid %b exp 1 0", bus.stallMem, bus.src1Valid); end
    bus.memRespValid = 1; bus.memRespData = 32'h88;
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.src1Valid !== 1'b1 || bus.src1Reg !== 5'd8 || bus.src1Value !== 32'h88) begin tests_failed++; $display("FAIL flush_second got valid %b reg %0d val %h exp 1 8 88", bus.src1Valid, bus.src1Reg, bus.src1Value); end
    next_cycle(); @(negedge clk);
    tests_run++; if (bus.wbEn !== 1'b1 || bus.wbReg !== 5'd8 || bus.wbValue !== 32'h88) begin tests_failed++; $display("FAIL flush_wb got en %b reg %0d val %h exp 1 8 88", bus.wbEn, bus.wbReg, bus.wbValue); end
  endtask

  task automatic test_flush_resp_same();
    do_reset();
    issue(5'd9, 1'b0, 32'h0);
    next_cycle(); idle(); bus.flush = 1; bus.memRespValid = 1; bus.memRespData = 32'h99;
    next_cycle(); idle(); issue(5'd10, 1'b0, 32'h0);
    next_cycle(); idle(); bus.memRespValid = 1; bus.memRespData = 32'hAA;
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.src1Valid !== 1'b1 || bus.src1Reg !== 5'd10 || bus.src1Value !== 32'hAA) begin tests_failed++; $display("FAIL flushresp_same got valid %b reg %0d val %h exp 1 10 aa", bus.src1Valid, bus.src1Reg, bus.src1Value); end
  endtask

  task automatic test_hold();
    do_reset();
    pulses = 0;
    issue(5'd3, 1'b1, 32'h11);
    next_cycle(); issue(5'd4, 1'b1, 32'h22);
    next_cycle(); issue(5'd6, 1'b1, 32'h66); bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (bus.wbEn !== 1'b0 || bus.src1Reg !== 5'd4 || bus.src2Reg !== 5'd3 || bus.src1Value !== 32'h22 || bus.src2Value !== 32'h11) begin tests_failed++; $display("FAIL hold_stable_%0d got wbEn %b r1 %0d r2 %0d v1 %h v2 %h exp 0 4 3 22 11", i, bus.wbEn, bus.src1Reg, bus.src2Reg, bus.src1Value, bus.src2Value); end
      next_cycle();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wbEn === 1'b1) pulses++;
      if (i == 0) begin
        tests_run++; if (bus.wbEn !== 1'b1 || bus.wbReg !== 5'd3) begin tests_failed++; $display("FAIL hold_release_first got en %b reg %0d exp 1 3", bus.wbEn, bus.wbReg); end
      end
      if (i == 1) begin
        tests_run++; if (bus.wbEn !== 1'b1 || bus.wbReg !== 5'd4) begin tests_failed++; $display("FAIL hold_release_second got en %b reg %0d exp 1 4", bus.wbEn, bus.wbReg); end
      end
      next_cycle();
    end
    tests_run++; if (pulses !== 2) begin tests_failed++; $display("FAIL hold_pulse_count got %0d exp 2", pulses); end
  endtask

  task automatic test_reg0();
    do_reset();
    pulses = 0;
    issue(5'd0, 1'b0, 32'h0);
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.stallMem !== 1'b1 || bus.src1Reg !== 5'd0) begin tests_failed++; $display("FAIL reg0_stall got stall %b reg %0d exp 1 0", bus.stallMem, bus.src1Reg); end
    next_cycle(); bus.memRespValid = 1; bus.memRespData = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wbEn === 1'b1) pulses++;
      next_cycle(); idle();
    end
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL reg0_no_wb got %0d pulses exp 0", pulses); end
    tests_run++; if (bus.stallMem !== 1'b0) begin tests_failed++; $display("FAIL reg0_released got stall %b exp 0", bus.stallMem); end
  endtask

  task automatic test_timeout();
    do_reset();
    issue(5'd2, 1'b0, 32'h0);
    next_cycle(); idle();
    repeat (3) next_cycle();
    @(negedge clk);
    tests_run++; if (bus.respTimeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_early got %b exp 0", bus.respTimeout); end
    next_cycle(); @(negedge clk);
    tests_run++; if (bus.respTimeout !== 1'b1 || bus.stallMem !== 1'b1) begin tests_failed++; $display("FAIL timeout_set got to %b stall %b exp 1 1", bus.respTimeout, bus.stallMem); end
    bus.memRespValid = 1; bus.memRespData = 32'h2;
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.respTimeout !== 1'b1 || bus.stallMem !== 1'b0) begin tests_failed++; $display("FAIL timeout_sticky got to %b stall %b exp 1 0", bus.respTimeout, bus.stallMem); end
    issue(5'd6, 1'b0, 32'h0);
    next_cycle(); idle(); @(negedge clk);
    tests_run++; if (bus.stallMem !== 1'b1) begin tests_failed++; $display("FAIL timeout_second_load got stall %b exp 1", bus.stallMem); end
    #2 resetn = 0;
    #1;
    tests_run++; if ({bus.stallMem, bus.respTimeout, bus.src1Reg, bus.src2Valid, bus.wbEn} !== 9'b0) begin tests_failed++; $display("FAIL midstall_reset got %b exp 0", {bus.stallMem, bus.respTimeout, bus.src1Reg, bus.src2Valid, bus.wbEn}); end
    next_cycle(); resetn = 1; @(negedge clk);
    tests_run++; if (bus.stallMem !== 1'b0 || bus.respTimeout !== 1'b0) begin tests_failed++; $display("FAIL midstall_after got stall %b to %b exp 0 0", bus.stallMem, bus.respTimeout); end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_flush_drop();
    test_flush_resp_same();
    test_hold();
    test_reg0();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
